// File: rtl/if_fetch_sequencer.sv
// IF-stage fetch sequencer: owns the fetch PC, drives a single-outstanding
// inst-SRAM request, buffers one instruction for ID, applies branch/exception redirects.
module if_fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        br_valid,
    input  logic [31:0] br_target,
    input  logic        exc_valid,
    input  logic [31:0] exc_target,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    output logic        fs_valid,
    output logic [31:0] fs_pc,
    output logic [31:0] fs_inst,
    input  logic        ds_allowin
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT
    } state_t;

    state_t      r_state;
    logic [31:0] r_fetch_pc;
    logic [31:0] r_req_pc;
    logic        r_cancel;
    logic        r_redir_pend;
    logic [31:0] r_redir_pc;
    logic        r_fs_valid;
    logic [31:0] r_fs_pc;
    logic [31:0] r_fs_inst;

    logic        w_live;
    logic        w_issue;
    logic        w_data_hit;
    logic        w_fill;

    // At most one instruction is live, so the live count collapses to a single bit.
    assign w_live     = r_fs_valid | ((r_state != S_IDLE) & ~r_cancel);
    assign w_issue    = (r_state == S_IDLE) & (~r_fs_valid | ds_allowin) & ~exc_valid;
    assign w_data_hit = (r_state == S_WAIT) & inst_data_ok;
    assign w_fill     = w_data_hit & ~r_cancel & ~exc_valid;

    assign inst_req  = (r_state == S_REQ);
    assign inst_addr = r_req_pc;
    assign fs_valid  = r_fs_valid;
    assign fs_pc     = r_fs_pc;
    assign fs_inst   = r_fs_inst;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= S_IDLE;
            r_fetch_pc   <= RESET_PC;
            r_req_pc     <= '0;
            r_cancel     <= 1'b0;
            r_redir_pend <= 1'b0;
            r_redir_pc   <= '0;
            r_fs_valid   <= 1'b0;
            r_fs_pc      <= '0;
            r_fs_inst    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_issue) begin
                        r_state  <= S_REQ;
                        r_req_pc <= r_fetch_pc;
                    end
                end
                S_REQ: begin
                    if (inst_addr_ok) r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (inst_data_ok) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase

            // Later assignments override earlier ones: issue < branch < exception.
            if (w_issue) begin
                r_fetch_pc   <= r_redir_pend ? r_redir_pc : r_fetch_pc + 32'd4;
                r_redir_pend <= 1'b0;
            end
            if (br_valid && !exc_valid) begin
                if (w_live || w_issue) begin
                    r_fetch_pc <= br_target;
                end else begin
                    r_redir_pend <= 1'b1;
                    r_redir_pc   <= br_target;
                end
            end
            if (exc_valid) begin
                r_fetch_pc   <= exc_target;
                r_redir_pend <= 1'b0;
            end

            if (w_data_hit) begin
                r_cancel <= 1'b0;
            end else if (exc_valid && (r_state != S_IDLE)) begin
                r_cancel <= 1'b1;
            end

            if (exc_valid) begin
                r_fs_valid <= 1'b0;
            end else if (w_fill) begin
                r_fs_valid <= 1'b1;
                r_fs_pc    <= r_req_pc;
                r_fs_inst  <= inst_rdata;
            end else if (ds_allowin) begin
                r_fs_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_if_fetch_sequencer.sv
// Directed-vector bench for if_fetch_sequencer; a tiny memory returns addr ^ FFFF0000.
module tb_if_fetch_sequencer;

    localparam logic [31:0] BASE = 32'hBFC0_0000;
    localparam logic [31:0] MASK = 32'hFFFF_0000;

    logic        clk = 1'b0;
    logic        resetn;
    logic        br_valid;
    logic [31:0] br_target;
    logic        exc_valid;
    logic [31:0] exc_target;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        fs_valid;
    logic [31:0] fs_pc;
    logic [31:0] fs_inst;
    logic        ds_allowin;

    logic [31:0] acc_addr = '0;

    int unsigned n_chk  = 0;
    int unsigned n_fail = 0;

    typedef struct {
        logic        al;
        logic        ao;
        logic        dok;
        logic        br;
        logic [31:0] brt;
        logic        exc;
        logic [31:0] exct;
        logic        req;
        logic [31:0] addr;
        logic        fsv;
        logic [31:0] pc;
    } vec_t;

    vec_t tbl[$];

    if_fetch_sequencer #(.RESET_PC(32'hBFC0_0000)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .br_valid     (br_valid),
        .br_target    (br_target),
        .exc_valid    (exc_valid),
        .exc_target   (exc_target),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .fs_valid     (fs_valid),
        .fs_pc        (fs_pc),
        .fs_inst      (fs_inst),
        .ds_allowin   (ds_allowin)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (inst_req && inst_addr_ok) acc_addr <= inst_addr;
    end
    assign inst_rdata = acc_addr ^ MASK;

    function automatic vec_t mk(input logic al, input logic ao, input logic dok,
                                input logic br, input logic [15:0] brt,
                                input logic exc, input logic [15:0] exct,
                                input logic req, input logic [15:0] addr,
                                input logic fsv, input logic [15:0] pc);
        vec_t v;
        v.al   = al;
        v.ao   = ao;
        v.dok  = dok;
        v.br   = br;
        v.brt  = BASE | {16'h0, brt};
        v.exc  = exc;
        v.exct = BASE | {16'h0, exct};
        v.req  = req;
        v.addr = BASE | {16'h0, addr};
        v.fsv  = fsv;
        v.pc   = BASE | {16'h0, pc};
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run(input vec_t v, input string tag);
        ds_allowin   = v.al;
        inst_addr_ok = v.ao;
        inst_data_ok = v.dok;
        br_valid     = v.br;
        br_target    = v.brt;
        exc_valid    = v.exc;
        exc_target   = v.exct;
        @(posedge clk);
        #1;
        chk({tag, ".inst_req"}, {31'b0, inst_req}, {31'b0, v.req});
        chk({tag, ".inst_addr"}, inst_addr, v.addr);
        chk({tag, ".fs_valid"}, {31'b0, fs_valid}, {31'b0, v.fsv});
        if (v.fsv) begin
            chk({tag, ".fs_pc"}, fs_pc, v.pc);
            chk({tag, ".fs_inst"}, fs_inst, v.pc ^ MASK);
        end
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, ".inst_req"}, {31'b0, inst_req}, 32'd0);
        chk({tag, ".inst_addr"}, inst_addr, 32'd0);
        chk({tag, ".fs_valid"}, {31'b0, fs_valid}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset-release stream, 10-cycle ID stall, then branch at 10 with delay slot in flight.
        tbl.push_back(mk(1,1,1,0,0,0,0, 1,'h000,0,0));
        tbl.push_back(mk(1,1,1,0,0,0,0, 0,'h000,0,0));
        tbl.push_back(mk(1,1,1,0,0,0,0, 0,'h000,1,'h000));
        tbl.push_back(mk(1,1,1,0,0,0,0, 1,'h004,0,0));
        tbl.push_back(mk(1,1,1,0,0,0,0, 0,'h004,0,0));
        tbl.push_back(mk(1,1,1,0,0,0,0, 0,'h004,1,'h004));
        for (int i = 0; i < 10; i++)
            tbl.push_back(mk(0,1,1,0,0,0,0, 0,'h004,1,'h004));
        tbl.push_back(mk(1,1,1,0,0,0,0, 1,'h008,0,0));
        tbl.push_back(mk(1,1,1,0,0,0,0, 0,'h008,0,0));
        tbl.push_back(mk(1,1,1,0,0,0,0, 0,'h008,1,'h008));
        tbl.push_back(mk(1,1,1,0,0,0,0, 1,'h00C,0,0));
        tbl.push_back(mk(1,1,1,0,0,0,0, 0,'h00C,0,0));
        tbl.push_back(mk(1,1,1,0,0,0,0, 0,'h00C,1,'h00C));
        tbl.push_back(mk(1,1,1,0,0,0,0, 1,'h010,0,0));
        tbl.push_back(mk(1,1,1,0,0,0,0, 0,'h010,0,0));
        tbl.push_back(mk(1,1,1,0,0,0,0, 0,'h010,1,'h010));
        tbl.push_back(mk(1,1,1,0,0,0,0, 1,'h014,0,0));
        tbl.push_back(mk(1,1,1,1,'h100,0,0, 0,'h014,0,0));
        tbl.push_back(mk(1,1,1,0,0,0,0, 0,'h014,1,'h014));
        tbl.push_back(mk(1,1,1,0,0,0,0, 1,'h100,0,0));
        tbl.push_back(mk(1,1,1,0,0,0,0, 0,'h100,0,0));
        tbl.push_back(mk(1,1,1,0,0,0,0, 0,'h100,1,'h100));

        resetn       = 1'b0;
        ds_allowin   = 1'b0;
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        br_valid     = 1'b0;
        br_target    = '0;
        exc_valid    = 1'b0;
        exc_target   = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outs("reset");
        chk("reset.fs_pc", fs_pc, 32'd0);
        chk("reset.fs_inst", fs_inst, 32'd0);
        @(negedge clk);
        resetn = 1'b1;

        foreach (tbl[i]) run(tbl[i], $sformatf("tbl[%0d]", i));

        // Branch with nothing live while a request issues: that request is the delay slot.
        run(mk(0,1,1,0,0,1,'h010, 0,'h100,0,0), "b0");
        run(mk(0,1,1,0,0,0,0,     1,'h010,0,0), "b1");
        run(mk(0,1,1,0,0,0,0,     0,'h010,0,0), "b2");
        run(mk(0,1,1,0,0,0,0,     0,'h010,1,'h010), "b3");
        run(mk(0,1,1,0,0,1,'h014, 0,'h010,0,0), "b4");
        run(mk(0,1,1,1,'h100,0,0, 1,'h014,0,0), "b5");
        run(mk(0,1,1,0,0,0,0,     0,'h014,0,0), "b6");
        run(mk(0,1,1,0,0,0,0,     0,'h014,1,'h014), "b7");
        run(mk(1,1,1,0,0,0,0,     1,'h100,0,0), "b8");
        run(mk(1,1,1,0,0,0,0,     0,'h100,0,0), "b9");
        run(mk(0,1,1,0,0,0,0,     0,'h100,1,'h100), "b10");

        // Branch with nothing live and no issue: held as pending redirect.
        run(mk(0,1,1,0,0,1,'h010, 0,'h100,0,0), "c1");
        run(mk(0,1,1,0,0,0,0,     1,'h010,0,0), "c2");
        run(mk(0,1,0,0,0,1,'h014, 0,'h010,0,0), "c3");
        run(mk(0,1,0,1,'h100,0,0, 0,'h010,0,0), "c4");
        run(mk(0,1,1,0,0,0,0,     0,'h010,0,0), "c5");
        run(mk(0,1,1,0,0,0,0,     1,'h014,0,0), "c6");
        run(mk(0,1,1,0,0,0,0,     0,'h014,0,0), "c7");
        run(mk(0,1,1,0,0,0,0,     0,'h014,1,'h014), "c8");
        run(mk(1,1,1,0,0,0,0,     1,'h100,0,0), "c9");
        run(mk(1,1,1,0,0,0,0,     0,'h100,0,0), "c10");
        run(mk(0,1,1,0,0,0,0,     0,'h100,1,'h100), "c11");

        // Exception while waiting on data for 0x20: returned data is dropped.
        run(mk(0,1,1,0,0,1,'h020, 0,'h100,0,0), "e1");
        run(mk(0,1,1,0,0,0,0,     1,'h020,0,0), "e2");
        run(mk(0,1,0,0,0,0,0,     0,'h020,0,0), "e3");
        run(mk(0,1,0,0,0,1,'h380, 0,'h020,0,0), "e4");
        run(mk(0,1,1,0,0,0,0,     0,'h020,0,0), "e5");
        run(mk(0,1,1,0,0,0,0,     1,'h380,0,0), "e6");
        run(mk(0,1,1,0,0,0,0,     0,'h380,0,0), "e7");
        run(mk(0,1,1,0,0,0,0,     0,'h380,1,'h380), "e8");

        // Exception and branch together; then exception coinciding with data_ok.
        run(mk(0,1,1,1,'h300,1,'h200, 0,'h380,0,0), "x1");
        run(mk(0,1,1,0,0,0,0,     1,'h200,0,0), "x2");
        run(mk(0,1,1,0,0,0,0,     0,'h200,0,0), "x3");
        run(mk(0,1,1,0,0,0,0,     0,'h200,1,'h200), "x4");
        run(mk(1,1,1,0,0,0,0,     1,'h204,0,0), "x5");
        run(mk(0,1,1,0,0,0,0,     0,'h204,0,0), "x6");
        run(mk(0,1,1,0,0,1,'h040, 0,'h204,0,0), "x7");
        run(mk(0,1,1,0,0,0,0,     1,'h040,0,0), "x8");
        run(mk(0,1,1,0,0,0,0,     0,'h040,0,0), "x9");
        run(mk(0,1,1,0,0,0,0,     0,'h040,1,'h040), "x10");

        // Asynchronous reset while a request is held in REQ.
        run(mk(1,0,0,0,0,0,0, 1,'h044,0,0), "ra1");
        run(mk(0,0,0,0,0,0,0, 1,'h044,0,0), "ra2");
        #3 resetn = 1'b0;
        #1 chk_reset_outs("rst_in_req");
        inst_addr_ok = 1'b1;
        inst_data_ok = 1'b1;
        @(negedge clk);
        resetn = 1'b1;

        // Asynchronous reset mid-WAIT with addr_ok held high.
        run(mk(0,1,1,0,0,0,0, 1,'h000,0,0), "rb1");
        run(mk(0,1,1,0,0,0,0, 0,'h000,0,0), "rb2");
        #3 resetn = 1'b0;
        #1 chk_reset_outs("rst_in_wait");
        repeat (2) @(posedge clk);
        #1 chk_reset_outs("rst_held");
        @(negedge clk);
        resetn = 1'b1;
        run(mk(0,1,1,0,0,0,0, 1,'h000,0,0), "rc1");
        run(mk(0,1,1,0,0,0,0, 0,'h000,0,0), "rc2");
        run(mk(0,1,1,0,0,0,0, 0,'h000,1,'h000), "rc3");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
